// File: rtl/piso_arb_pkg.sv
// Shared types and constants for the PISO transmit arbiter.
package piso_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} arb_state_e;

  localparam int PISO_WORD_W = 16;
  localparam int GAP_CNT_W   = 4;
  localparam int TO_CNT_W    = 16;
endpackage

// File: rtl/piso_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any_req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);
  int j;

  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    j         = 0;
    // k=NUM_REQ revisits ptr itself last, so a lone requester at ptr still wins
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any_req && req[j]) begin
        any_req   = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
    grant = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter feeding one PISO serializer; optional watchdog under
// PISO_ARB_WATCHDOG_EN.
module piso_tx_arbiter
  import piso_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = PISO_WORD_W,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      piso_valid_data,
  output logic [DATA_W-1:0]         piso_in,
  input  logic                      piso_done,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      tx_done,
  output logic                      timeout_err
);
  arb_state_e           state, state_n;
  logic [IDX_W-1:0]     ptr;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 any_req;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 grant_fire, done_fire, to_fire;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .any_req   (any_req),
    .grant     (pick_oh),
    .grant_idx (pick_idx)
  );

`ifdef PISO_ARB_WATCHDOG_EN
  logic [TO_CNT_W-1:0] to_cnt;
  assign to_fire = (state == WAIT_DONE) && !piso_done &&
                   (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        grant_fire = 1'b1;
        state_n    = WAIT_DONE;
      end
      WAIT_DONE: if (piso_done) begin
        done_fire = 1'b1;
        state_n   = (GAP_CYCLES > 0) ? GAP : IDLE;
      end else if (to_fire) begin
        state_n = IDLE;
      end
      GAP: if (gap_cnt == GAP_CNT_W'(GAP_CYCLES - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= IDX_W'(NUM_REQ - 1);
      gap_cnt         <= '0;
      req_ready       <= '0;
      piso_valid_data <= 1'b0;
      piso_in         <= '0;
      grant_id        <= '0;
      tx_done         <= 1'b0;
    end else begin
      state           <= state_n;
      piso_valid_data <= grant_fire;
      req_ready       <= grant_fire ? pick_oh : '0;
      tx_done         <= done_fire;
      gap_cnt         <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (grant_fire) begin
        piso_in  <= req_data[pick_idx*DATA_W +: DATA_W];
        grant_id <= pick_idx;
        ptr      <= pick_idx;
      end
    end
  end

`ifdef PISO_ARB_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_DONE) ? to_cnt + 1'b1 : '0;
      if (to_fire) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  assign busy = (state != IDLE);
endmodule
